// File: rtl/axil_apb3_bridge_mx_if.sv
// Bus bundle for the AXI4-Lite to APB3 bridge: the AXI4-Lite slave port and
// the shared APB3 master bus with per-peripheral select/ready/error/read data.
interface axil_apb3_bridge_mx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_SLAVES = 4
);
  // AXI4-Lite
  logic [31:0]               S_AXI_AWADDR;
  logic                      S_AXI_AWVALID;
  logic                      S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                      S_AXI_WVALID;
  logic                      S_AXI_WREADY;
  logic [1:0]                S_AXI_BRESP;
  logic                      S_AXI_BVALID;
  logic                      S_AXI_BREADY;
  logic [31:0]               S_AXI_ARADDR;
  logic                      S_AXI_ARVALID;
  logic                      S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                S_AXI_RRESP;
  logic                      S_AXI_RVALID;
  logic                      S_AXI_RREADY;
  // APB3
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic                             PWRITE;
  logic                             PENABLE;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic [NUM_SLAVES-1:0]            PSEL;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]            PREADY;
  logic [NUM_SLAVES-1:0]            PSLVERR;

  // Bridge side: AXI slave, APB master
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    input  PRDATA, PREADY, PSLVERR
  );

  // Environment side: AXI master, APB peripherals
  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/axil_apb3_bridge_mx.sv
// AXI4-Lite slave to APB3 master bridge with NUM_SLAVES peripherals.
// One AW, one W and one AR are buffered; a single APB FSM serves them with
// alternating priority when both a write and a read are pending. Unmapped
// addresses answer DECERR, partial-strobe writes and PREADY timeouts SLVERR.
module axil_apb3_bridge_mx #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axil_apb3_bridge_mx_if.slave  bus
);
  localparam int SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_BRESP, S_RRESP} state_t;

  state_t                state_q, state_d;
  logic                  have_aw_q, have_aw_d, have_w_q, have_w_d, have_ar_q, have_ar_d;
  logic [31:0]           awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  last_wr_q, last_wr_d;   // 0 = last grant was a read
  logic                  cur_wr_q, cur_wr_d;
  logic [SIDX_W-1:0]     cur_sidx_q, cur_sidx_d;
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  // registered outputs
  logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  // arbitration / decode helpers
  logic                  wr_rdy, rd_rdy, grant_wr, unmapped;
  logic [31:0]           sel_addr;
  logic [SIDX_W-1:0]     sel_idx;

  // Next-state, capture, arbitration/decode and APB/AXI output sequencing
  always_comb begin
    state_d    = state_q;
    have_aw_d  = have_aw_q;
    have_w_d   = have_w_q;
    have_ar_d  = have_ar_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    last_wr_d  = last_wr_q;
    cur_wr_d   = cur_wr_q;
    cur_sidx_d = cur_sidx_q;
    tmo_cnt_d  = tmo_cnt_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    rdata_d    = rdata_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;

    if (awready_q && bus.S_AXI_AWVALID) begin
      have_aw_d = 1'b1;
      awaddr_d  = bus.S_AXI_AWADDR;
    end
    if (wready_q && bus.S_AXI_WVALID) begin
      have_w_d = 1'b1;
      wdata_d  = bus.S_AXI_WDATA;
      wstrb_d  = bus.S_AXI_WSTRB;
    end
    if (arready_q && bus.S_AXI_ARVALID) begin
      have_ar_d = 1'b1;
      araddr_d  = bus.S_AXI_ARADDR;
    end

    wr_rdy   = have_aw_q & have_w_q;
    rd_rdy   = have_ar_q;
    grant_wr = wr_rdy & (~rd_rdy | ~last_wr_q);
    sel_addr = grant_wr ? awaddr_q : araddr_q;
    sel_idx  = sel_addr[ADDR_WIDTH +: SIDX_W];
    unmapped = ((sel_addr >> (ADDR_WIDTH + SIDX_W)) != 32'd0) ||
               (32'(sel_idx) >= NUM_SLAVES);

    case (state_q)
      S_IDLE: begin
        if (wr_rdy || rd_rdy) begin
          cur_wr_d = grant_wr;
          if (unmapped) begin
            if (grant_wr) begin
              bvalid_d = 1'b1;
              bresp_d  = 2'b11;
              state_d  = S_BRESP;
            end else begin
              rvalid_d = 1'b1;
              rresp_d  = 2'b11;
              rdata_d  = '0;
              state_d  = S_RRESP;
            end
          end else if (grant_wr && (wstrb_q != {STRB_W{1'b1}})) begin
            bvalid_d = 1'b1;
            bresp_d  = 2'b10;
            state_d  = S_BRESP;
          end else begin
            psel_d          = '0;
            psel_d[sel_idx] = 1'b1;
            penable_d       = 1'b0;
            paddr_d         = sel_addr[ADDR_WIDTH-1:0];
            pwrite_d        = grant_wr;
            if (grant_wr) pwdata_d = wdata_q;
            last_wr_d       = grant_wr;
            cur_sidx_d      = sel_idx;
            state_d         = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        tmo_cnt_d = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.PREADY[cur_sidx_q]) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (cur_wr_q) begin
            bvalid_d = 1'b1;
            bresp_d  = bus.PSLVERR[cur_sidx_q] ? 2'b10 : 2'b00;
            state_d  = S_BRESP;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = bus.PSLVERR[cur_sidx_q] ? 2'b10 : 2'b00;
            rdata_d  = bus.PRDATA[cur_sidx_q*DATA_WIDTH +: DATA_WIDTH];
            state_d  = S_RRESP;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (32'(tmo_cnt_q) == TIMEOUT_CYCLES - 1)) begin
          // peripheral never answered: abandon the access with SLVERR
          psel_d    = '0;
          penable_d = 1'b0;
          if (cur_wr_q) begin
            bvalid_d = 1'b1;
            bresp_d  = 2'b10;
            state_d  = S_BRESP;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = 2'b10;
            rdata_d  = '0;
            state_d  = S_RRESP;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_BRESP: begin
        if (bvalid_q && bus.S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          have_aw_d = 1'b0;
          have_w_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_RRESP: begin
        if (rvalid_q && bus.S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          have_ar_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    awready_d = ~have_aw_d;
    wready_d  = ~have_w_d;
    arready_d = ~have_ar_d;
  end

  // State and output registers; reset clears control and every output
  always_ff @(posedge ACLK) begin
    awaddr_q <= awaddr_d;
    araddr_q <= araddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
    if (ARESET) begin
      state_q    <= S_IDLE;
      have_aw_q  <= 1'b0;
      have_w_q   <= 1'b0;
      have_ar_q  <= 1'b0;
      last_wr_q  <= 1'b0;
      cur_wr_q   <= 1'b0;
      cur_sidx_q <= '0;
      tmo_cnt_q  <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      rdata_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      have_aw_q  <= have_aw_d;
      have_w_q   <= have_w_d;
      have_ar_q  <= have_ar_d;
      last_wr_q  <= last_wr_d;
      cur_wr_q   <= cur_wr_d;
      cur_sidx_q <= cur_sidx_d;
      tmo_cnt_q  <= tmo_cnt_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      rdata_q    <= rdata_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
  end

  assign bus.S_AXI_AWREADY = awready_q;
  assign bus.S_AXI_WREADY  = wready_q;
  assign bus.S_AXI_ARREADY = arready_q;
  assign bus.S_AXI_BVALID  = bvalid_q;
  assign bus.S_AXI_BRESP   = bresp_q;
  assign bus.S_AXI_RVALID  = rvalid_q;
  assign bus.S_AXI_RRESP   = rresp_q;
  assign bus.S_AXI_RDATA   = rdata_q;
  assign bus.PSEL          = psel_q;
  assign bus.PENABLE       = penable_q;
  assign bus.PWRITE        = pwrite_q;
  assign bus.PADDR         = paddr_q;
  assign bus.PWDATA        = pwdata_q;
endmodule

// File: tb/tb_axil_apb3_bridge_mx.sv
// Directed bench for axil_apb3_bridge_mx: four APB peripherals modelled by
// per-slave PREADY/PSLVERR/PRDATA drives; TIMEOUT_CYCLES set to 8.
module tb_axil_apb3_bridge_mx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  axil_apb3_bridge_mx_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_SLAVES(4)) bif ();

  axil_apb3_bridge_mx #(
    .DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_SLAVES(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .ACLK  (clk),
    .ARESET(rst),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  // APB activity log taken on the falling edge
  bit   ord_q[$];
  int   acc_cycles = 0;
  logic multi_psel = 1'b0;
  always @(negedge clk) begin
    if (bif.PSEL != 4'b0 && !bif.PENABLE) ord_q.push_back(bif.PWRITE);
    if (bif.PSEL != 4'b0 && bif.PENABLE) acc_cycles++;
    if ($countones(bif.PSEL) > 1) multi_psel = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n;
    bif.S_AXI_AWADDR = a; bif.S_AXI_WDATA = d; bif.S_AXI_WSTRB = s;
    bif.S_AXI_AWVALID = 1'b1; bif.S_AXI_WVALID = 1'b1;
    n = 0;
    while (!(bif.S_AXI_AWREADY && bif.S_AXI_WREADY) && n < 50) begin tick(); n++; end
    tick();
    bif.S_AXI_AWVALID = 1'b0; bif.S_AXI_WVALID = 1'b0;
    bif.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!bif.S_AXI_BVALID && n < 100) begin tick(); n++; end
    chk("bvalid_seen", bif.S_AXI_BVALID, 1);
    resp = bif.S_AXI_BRESP;
    tick();
    bif.S_AXI_BREADY = 1'b0;
  endtask

  task automatic issue_ar(input logic [31:0] a);
    int n;
    bif.S_AXI_ARADDR = a; bif.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bif.S_AXI_ARREADY && n < 50) begin tick(); n++; end
    tick();
    bif.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [1:0] resp, output logic [31:0] d);
    int n;
    issue_ar(a);
    bif.S_AXI_RREADY = 1'b1;
    n = 0;
    while (!bif.S_AXI_RVALID && n < 100) begin tick(); n++; end
    chk("rvalid_seen", bif.S_AXI_RVALID, 1);
    resp = bif.S_AXI_RRESP;
    d    = bif.S_AXI_RDATA;
    tick();
    bif.S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_pair(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                         output logic [1:0] br, output logic [1:0] rr, output logic [31:0] rd);
    int   n;
    logic got_b, got_r;
    bif.S_AXI_AWADDR = wa; bif.S_AXI_WDATA = wd; bif.S_AXI_WSTRB = 4'hF;
    bif.S_AXI_ARADDR = ra;
    bif.S_AXI_AWVALID = 1'b1; bif.S_AXI_WVALID = 1'b1; bif.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!(bif.S_AXI_AWREADY && bif.S_AXI_WREADY && bif.S_AXI_ARREADY) && n < 50) begin
      tick(); n++;
    end
    tick();
    bif.S_AXI_AWVALID = 1'b0; bif.S_AXI_WVALID = 1'b0; bif.S_AXI_ARVALID = 1'b0;
    bif.S_AXI_BREADY = 1'b1; bif.S_AXI_RREADY = 1'b1;
    got_b = 1'b0; got_r = 1'b0; br = 2'bxx; rr = 2'bxx; rd = 'x;
    n = 0;
    while (!(got_b && got_r) && n < 100) begin
      if (bif.S_AXI_BVALID && !got_b) begin br = bif.S_AXI_BRESP; got_b = 1'b1; end
      if (bif.S_AXI_RVALID && !got_r) begin rr = bif.S_AXI_RRESP; rd = bif.S_AXI_RDATA; got_r = 1'b1; end
      tick(); n++;
    end
    bif.S_AXI_BREADY = 1'b0; bif.S_AXI_RREADY = 1'b0;
    chk("pair_done", {got_b, got_r}, 2'b11);
  endtask

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;
    int          sz, n;

    bif.S_AXI_AWADDR = '0; bif.S_AXI_AWVALID = 1'b0;
    bif.S_AXI_WDATA  = '0; bif.S_AXI_WSTRB   = '0; bif.S_AXI_WVALID = 1'b0;
    bif.S_AXI_BREADY = 1'b0;
    bif.S_AXI_ARADDR = '0; bif.S_AXI_ARVALID = 1'b0; bif.S_AXI_RREADY = 1'b0;
    bif.PRDATA  = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    bif.PREADY  = 4'hF;
    bif.PSLVERR = 4'h0;

    // reset state
    repeat (3) tick();
    chk("rst_awready", bif.S_AXI_AWREADY, 0);
    chk("rst_arready", bif.S_AXI_ARREADY, 0);
    chk("rst_psel", bif.PSEL, 0);
    chk("rst_valids", {bif.S_AXI_BVALID, bif.S_AXI_RVALID, bif.PENABLE}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_readies", {bif.S_AXI_AWREADY, bif.S_AXI_WREADY, bif.S_AXI_ARREADY}, 3'b111);

    // simultaneous write+read after reset: write wins (last grant was read)
    sz = ord_q.size();
    do_pair(32'h0000_0010, 32'h1111_2222, 32'h0000_0020, br, rr, rd);
    chk("pair1_bresp", br, 2'b00);
    chk("pair1_rresp", rr, 2'b00);
    chk("pair1_rdata", rd, 32'hCAFE_0000);
    chk("pair1_first_is_write", ord_q[sz], 1);
    chk("pair1_second_is_read", ord_q[sz+1], 0);

    // single write with minimum latency timing
    bif.S_AXI_AWADDR = 32'h0000_1004; bif.S_AXI_WDATA = 32'hA5A5_A5A5; bif.S_AXI_WSTRB = 4'hF;
    bif.S_AXI_AWVALID = 1'b1; bif.S_AXI_WVALID = 1'b1;
    tick();                                   // edge N: handshake
    bif.S_AXI_AWVALID = 1'b0; bif.S_AXI_WVALID = 1'b0;
    chk("w1_awready_drop", bif.S_AXI_AWREADY, 0);
    tick();                                   // edge N+1: SETUP
    chk("w1_setup_psel", bif.PSEL, 4'b0010);
    chk("w1_setup_penable", bif.PENABLE, 0);
    chk("w1_paddr", bif.PADDR, 12'h004);
    chk("w1_pwrite", bif.PWRITE, 1);
    chk("w1_pwdata", bif.PWDATA, 32'hA5A5_A5A5);
    tick();                                   // edge N+2: ACCESS
    chk("w1_access", {bif.PSEL, bif.PENABLE, bif.S_AXI_BVALID}, {4'b0010, 1'b1, 1'b0});
    tick();                                   // edge N+3: response
    chk("w1_bvalid", bif.S_AXI_BVALID, 1);
    chk("w1_bresp", bif.S_AXI_BRESP, 2'b00);
    chk("w1_psel_off", {bif.PSEL, bif.PENABLE}, 0);
    bif.S_AXI_BREADY = 1'b1;
    tick();
    bif.S_AXI_BREADY = 1'b0;
    chk("w1_bvalid_clear", bif.S_AXI_BVALID, 0);

    // last grant is now a write, so the next pair goes read first
    sz = ord_q.size();
    do_pair(32'h0000_0030, 32'h3333_4444, 32'h0000_1040, br, rr, rd);
    chk("pair2_bresp", br, 2'b00);
    chk("pair2_rdata", rd, 32'hCAFE_0001);
    chk("pair2_first_is_read", ord_q[sz], 0);
    chk("pair2_second_is_write", ord_q[sz+1], 1);

    // unmapped read, unmapped write, partial-strobe write: no APB cycle
    sz = ord_q.size();
    do_read(32'h0000_5000, rr, rd);
    chk("decerr_rresp", rr, 2'b11);
    chk("decerr_rdata", rd, 32'h0);
    do_write(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, br);
    chk("decerr_bresp", br, 2'b11);
    do_write(32'h0000_0008, 32'h1234_5678, 4'h3, br);
    chk("strb_bresp", br, 2'b10);
    chk("err_no_apb", ord_q.size() - sz, 0);

    // PREADY timeout on slave 2
    bif.PREADY = 4'b1011;
    acc_cycles = 0;
    do_read(32'h0000_2010, rr, rd);
    chk("tmo_access_cycles", acc_cycles, 8);
    chk("tmo_rresp", rr, 2'b10);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_psel_off", bif.PSEL, 0);
    bif.PREADY = 4'hF;

    // PSLVERR on read keeps the data
    bif.PSLVERR = 4'b1000;
    do_read(32'h0000_3000, rr, rd);
    chk("slverr_rresp", rr, 2'b10);
    chk("slverr_rdata", rd, 32'hCAFE_0003);
    bif.PSLVERR = 4'h0;

    // BREADY held low: response must stay put
    bif.S_AXI_AWADDR = 32'h0000_0000; bif.S_AXI_WDATA = 32'h0F0F_0F0F; bif.S_AXI_WSTRB = 4'hF;
    bif.S_AXI_AWVALID = 1'b1; bif.S_AXI_WVALID = 1'b1;
    tick();
    bif.S_AXI_AWVALID = 1'b0; bif.S_AXI_WVALID = 1'b0;
    n = 0;
    while (!bif.S_AXI_BVALID && n < 50) begin tick(); n++; end
    repeat (5) tick();
    chk("bhold_bvalid", bif.S_AXI_BVALID, 1);
    chk("bhold_bresp", bif.S_AXI_BRESP, 2'b00);
    bif.S_AXI_BREADY = 1'b1;
    tick();
    bif.S_AXI_BREADY = 1'b0;
    chk("bhold_release", bif.S_AXI_BVALID, 0);

    // reset in the middle of an ACCESS phase
    bif.PREADY = 4'b1101;
    issue_ar(32'h0000_1000);
    n = 0;
    while (!bif.PENABLE && n < 20) begin tick(); n++; end
    chk("mid_in_access", bif.PENABLE, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_apb", {bif.PSEL, bif.PENABLE}, 0);
    chk("mid_rst_valids", {bif.S_AXI_BVALID, bif.S_AXI_RVALID}, 0);
    rst = 1'b0;
    bif.PREADY = 4'hF;
    tick();
    do_read(32'h0000_1000, rr, rd);
    chk("post_rst_rresp", rr, 2'b00);
    chk("post_rst_rdata", rd, 32'hCAFE_0001);

    chk("psel_onehot", multi_psel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
